// File: rtl/fib_sweep_if.sv
// Bundles the fib request/response wires and the output-FIFO stream of fib_sweep.
// The sweep block uses the master modport; the fib calculator/consumer side uses the slave modport.
interface fib_sweep_if #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
);
    logic                    fib_go;
    logic [INPUT_WIDTH-1:0]  fib_n;
    logic [OUTPUT_WIDTH-1:0] fib_result;
    logic                    fib_overflow;
    logic                    fib_done;

    logic                    out_valid;
    logic                    out_ready;
    logic [INPUT_WIDTH-1:0]  out_n;
    logic [OUTPUT_WIDTH-1:0] out_result;
    logic                    out_overflow;

    modport master (
        output fib_go, fib_n, out_valid, out_n, out_result, out_overflow,
        input  fib_result, fib_overflow, fib_done, out_ready
    );

    modport slave (
        input  fib_go, fib_n, out_valid, out_n, out_result, out_overflow,
        output fib_result, fib_overflow, fib_done, out_ready
    );
endinterface

// File: rtl/fib_sweep.sv
// Sweeps n over an inclusive range, issuing one fib request per value and
// collecting {n, result, overflow} into a small FIFO drained by a valid/ready consumer.
module fib_sweep #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INPUT_WIDTH-1:0] n_first,
    input  logic [INPUT_WIDTH-1:0] n_last,
    output logic                   busy,
    output logic                   sweep_done,
    fib_sweep_if.master            bus
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INPUT_WIDTH + OUTPUT_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_CAPTURE   = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] cur_q, cur_d;
    logic [INPUT_WIDTH-1:0] last_q, last_d;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     mem_d [FIFO_DEPTH];

    logic                   fifo_full;
    logic                   fifo_valid;
    logic                   push;
    logic                   pop;
    logic                   at_last;
    logic [ENTRY_W-1:0]     head;

    // Fullness is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_valid = (count_q != '0);
    assign push       = (state_q == S_CAPTURE) && !fifo_full;
    assign pop        = fifo_valid && bus.out_ready;
    assign at_last    = (cur_q == last_q);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (n_first > n_last) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                // fib keeps done high from its previous run; wait for it to clear.
                if (!bus.fib_done) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (bus.fib_done) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!fifo_full) begin
                    state_d = at_last ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        busy       = (state_q != S_IDLE);
        sweep_done = (state_q == S_FINISH);
        bus.fib_go = (state_q == S_ISSUE);
        bus.fib_n  = cur_q;
    end

    // ---------------------------------------------------------------- range tracking
    always_comb begin
        cur_d  = cur_q;
        last_d = last_q;
        if ((state_q == S_IDLE) && start) begin
            cur_d  = n_first;
            last_d = n_last;
        end else if (push && !at_last) begin
            // Compare-before-increment: cur never steps past n_last, so the top code cannot wrap.
            cur_d = cur_q + INPUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    // ---------------------------------------------------------------- output FIFO
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cur_q, bus.fib_result, bus.fib_overflow};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage and the latched range end need no reset: both are only read once written.
    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        last_q <= last_d;
    end

    assign head = mem_q[rd_ptr_q];

    // Head fields are forced to zero while empty so the stream reads clean after reset or drain.
    always_comb begin
        bus.out_valid = fifo_valid;
        if (fifo_valid) begin
            {bus.out_n, bus.out_result, bus.out_overflow} = head;
        end else begin
            bus.out_n        = '0;
            bus.out_result   = '0;
            bus.out_overflow = 1'b0;
        end
    end

    // ---------------------------------------------------------------- properties
    a_go_single: assert property (@(posedge clk) disable iff (!rst)
        bus.fib_go |=> !bus.fib_go);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= FULL_CNT);

    a_go_busy: assert property (@(posedge clk) disable iff (!rst)
        bus.fib_go |-> busy);

endmodule

// File: tb/tb_fib_sweep.sv
// Randomized bench for fib_sweep: emulates the fib calculator, models expected entries
// per sweep from the range rules, and checks every popped entry plus directed scenarios.
`timescale 1ns/1ps
module tb_fib_sweep;
    localparam int IW    = 6;
    localparam int OW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [IW-1:0] n;
        logic [OW-1:0] r;
        logic          o;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] n_first = '0;
    logic [IW-1:0] n_last  = '0;
    logic          busy;
    logic          sweep_done;

    fib_sweep_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus();

    fib_sweep #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_first    (n_first),
        .n_last     (n_last),
        .busy       (busy),
        .sweep_done (sweep_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    entry_t exp_q[$];
    entry_t log_q[$];
    int     go_count = 0;
    int     sd_count = 0;

    bit rand_ready = 1'b0;
    bit ready_val  = 1'b0;
    int drop_min = 0, drop_max = 2, lat_min = 1, lat_max = 3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: F(0)=0, F(1)=1; result is the low 32 bits, overflow when F(n) needs more.
    function automatic entry_t model_entry(input int n);
        logic [63:0] a, b, t;
        entry_t e;
        a = 64'd0;
        b = 64'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        e.n = IW'(n);
        e.r = a[OW-1:0];
        e.o = (a[63:OW] != '0);
        return e;
    endfunction

    // Consumer ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // fib calculator stand-in: drops a stale done after a random delay, raises it after a random latency.
    initial begin : fib_emul
        bit            go_s, fm_busy;
        logic [IW-1:0] n_s, fm_n;
        int            fm_drop, fm_lat;
        entry_t        fe;
        bus.fib_done     = 1'b0;
        bus.fib_result   = '0;
        bus.fib_overflow = 1'b0;
        fm_busy = 1'b0;
        fm_n    = '0;
        fm_drop = 0;
        fm_lat  = 0;
        forever begin
            @(negedge clk);
            go_s = bus.fib_go;
            n_s  = bus.fib_n;
            @(posedge clk);
            #1;
            if (!rst) begin
                fm_busy      = 1'b0;
                bus.fib_done = 1'b0;
            end else if (go_s) begin
                chk("go_before_done", fm_busy, 0);
                fm_busy = 1'b1;
                fm_n    = n_s;
                fm_drop = $urandom_range(drop_min, drop_max);
                fm_lat  = $urandom_range(lat_min, lat_max);
                if (fm_drop == 0) bus.fib_done = 1'b0;
            end else if (fm_busy) begin
                chk("fib_n_stable", bus.fib_n, fm_n);
                if (fm_drop > 0) begin
                    fm_drop--;
                    if (fm_drop == 0) bus.fib_done = 1'b0;
                end else if (fm_lat > 1) begin
                    fm_lat--;
                end else begin
                    fe = model_entry(int'(fm_n));
                    bus.fib_result   = fe.r;
                    bus.fib_overflow = fe.o;
                    bus.fib_done     = 1'b1;
                    fm_busy          = 1'b0;
                end
            end
        end
    end

    // Compare process: every accepted head entry against the scoreboard, plus go/done pulse rules.
    bit prev_go = 1'b0;
    always @(negedge clk) begin
        entry_t e, a;
        if (!rst) begin
            prev_go = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                a = {bus.out_n, bus.out_result, bus.out_overflow};
                chk("entry_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_n", a.n, e.n);
                    chk("out_result", a.r, e.r);
                    chk("out_overflow", a.o, e.o);
                end
                log_q.push_back(a);
            end
            if (bus.fib_go) begin
                chk("go_consecutive", prev_go, 0);
                chk("go_while_busy", busy, 1);
                go_count++;
            end
            if (sweep_done) sd_count++;
            prev_go = bus.fib_go;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int a, input int b, input bit expect_it);
        n_first = IW'(a);
        n_last  = IW'(b);
        start   = 1'b1;
        if (expect_it && a <= b)
            for (int n = a; n <= b; n++) exp_q.push_back(model_entry(n));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        chk({tag, "_idle_timeout"}, busy, 0);
        tick();
    endtask

    task automatic drain(input int limit, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_drain_left"}, exp_q.size(), 0);
        chk({tag, "_drain_valid"}, bus.out_valid, 0);
        tick();
    endtask

    task automatic wait_go(input int g0, input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (go_count - g0 < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_go_timeout"}, go_count - g0 >= target, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g0, s0, l0, a, b;
        logic [63:0] basic_lit [10];
        logic [63:0] bp_lit [8];
        basic_lit = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
        bp_lit    = '{0, 1, 1, 2, 3, 5, 8, 13};

        // Reset held with toggling inputs.
        rand_ready = 1'b1;
        repeat (4) begin
            tick();
            start   = 1'($urandom_range(0, 1));
            n_first = IW'($urandom_range(0, 63));
            n_last  = IW'($urandom_range(0, 63));
            @(negedge clk);
            #1;
            chk("reset_outputs", {busy, sweep_done, bus.fib_go, bus.fib_n, bus.out_valid,
                                  bus.out_n, bus.out_result, bus.out_overflow}, 0);
        end
        start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        g0 = go_count;
        repeat (5) tick();
        chk("idle_no_go", go_count - g0, 0);
        chk("idle_busy", busy, 0);

        // Model pinned to hand values.
        chk("model_f10", model_entry(10).r, 55);
        chk("model_f47", model_entry(47).r, 64'd2971215073);

        // Basic sweep 1..10.
        g0 = go_count; s0 = sd_count; l0 = log_q.size();
        do_start(1, 10, 1);
        @(negedge clk);
        chk("basic_go_first", bus.fib_go, 1);
        chk("basic_busy_first", busy, 1);
        wait_idle(2000, "basic");
        drain(200, "basic");
        chk("basic_go_count", go_count - g0, 10);
        chk("basic_done_count", sd_count - s0, 1);
        chk("basic_entries", log_q.size() - l0, 10);
        for (int i = 0; i < 10; i++)
            if (l0 + i < log_q.size()) chk("basic_lit", log_q[l0 + i].r, basic_lit[i]);

        // Backpressure 0..7 with consumer stalled.
        ready_val = 1'b0;
        g0 = go_count; l0 = log_q.size();
        do_start(0, 7, 1);
        wait_go(g0, 5, 500, "bp");
        repeat (40) @(negedge clk);
        chk("bp_go_stall", go_count - g0, 5);
        chk("bp_busy", busy, 1);
        chk("bp_valid", bus.out_valid, 1);
        tick();
        ready_val = 1'b1;
        wait_idle(2000, "bp");
        drain(200, "bp");
        chk("bp_go_total", go_count - g0, 8);
        chk("bp_entries", log_q.size() - l0, 8);
        for (int i = 0; i < 8; i++)
            if (l0 + i < log_q.size()) chk("bp_lit", log_q[l0 + i].r, bp_lit[i]);

        // Empty range.
        g0 = go_count; s0 = sd_count;
        do_start(5, 3, 1);
        @(negedge clk);
        chk("empty_done", sweep_done, 1);
        chk("empty_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("empty_done_end", sweep_done, 0);
        chk("empty_busy_end", busy, 0);
        chk("empty_no_go", go_count - g0, 0);
        chk("empty_done_count", sd_count - s0, 1);
        tick();

        // Top of range, no wrap.
        g0 = go_count; l0 = log_q.size();
        do_start(63, 63, 1);
        wait_idle(2000, "top");
        drain(200, "top");
        chk("top_entries", log_q.size() - l0, 1);
        chk("top_go", go_count - g0, 1);
        chk("top_fib_n_hold", bus.fib_n, 63);
        if (log_q.size() > l0) chk("top_n", log_q[l0].n, 63);

        // Overflow boundary.
        l0 = log_q.size();
        do_start(47, 48, 1);
        wait_idle(2000, "ovf");
        drain(200, "ovf");
        chk("ovf_entries", log_q.size() - l0, 2);
        if (log_q.size() > l0 + 1) begin
            chk("ovf47_result", log_q[l0].r, 64'd2971215073);
            chk("ovf47_flag", log_q[l0].o, 0);
            chk("ovf48_flag", log_q[l0 + 1].o, 1);
        end

        // start pulsed during WAIT_HIGH is ignored.
        drop_min = 0; drop_max = 0; lat_min = 6; lat_max = 6;
        g0 = go_count; l0 = log_q.size();
        do_start(10, 14, 1);
        wait_go(g0, 2, 500, "ign");
        @(negedge clk);
        tick();
        do_start(1, 2, 0);
        wait_idle(2000, "ign");
        drain(200, "ign");
        chk("ign_go", go_count - g0, 5);
        chk("ign_entries", log_q.size() - l0, 5);
        if (log_q.size() > l0 + 4) chk("ign_last_n", log_q[l0 + 4].n, 14);

        // Reset during WAIT_LOW flushes the FIFO.
        drop_min = 4; drop_max = 4; lat_min = 2; lat_max = 3;
        ready_val = 1'b0;
        g0 = go_count;
        do_start(20, 25, 1);
        wait_go(g0, 2, 500, "rstmid");
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rstmid_valid", bus.out_valid, 0);
            chk("rstmid_busy", busy, 0);
            chk("rstmid_go_n", {bus.fib_go, bus.fib_n}, 0);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        drop_min = 0; drop_max = 2; lat_min = 1; lat_max = 3;
        ready_val = 1'b1;
        g0 = go_count; l0 = log_q.size();
        do_start(2, 6, 1);
        wait_idle(2000, "after_rst");
        drain(200, "after_rst");
        chk("after_rst_go", go_count - g0, 5);
        chk("after_rst_entries", log_q.size() - l0, 5);

        // Randomized sweeps with a random consumer.
        rand_ready = 1'b1;
        lat_max = 5;
        for (int t = 0; t < 12; t++) begin
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 5) == 0) b = (a == 0) ? 0 : a - 1;
            else begin
                b = a + $urandom_range(0, 5);
                if (b > 63) b = 63;
            end
            g0 = go_count;
            do_start(a, b, 1);
            wait_idle(3000, "rand");
            chk("rand_go", go_count - g0, (a <= b) ? b - a + 1 : 0);
        end
        drain(3000, "rand");
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
